hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter RA_W, default 5, meaning register-address width.
REQ-002 SHALL have parameter DEPTH, default 3, range 2..4, meaning number of tracked stages after decode.
REQ-003 SHALL have parameter NSRC, default 2, range 1..3, meaning number of source operands per instruction.
REQ-004 SHALL have parameter LOAD_READY, default 2, range 1..DEPTH, meaning first stage whose result bus carries load data.
REQ-005 SHALL have parameter FLUSH_CYCLES, default 1, range 1..3, meaning bubble count after a redirect.
REQ-006 SHALL use one clock and an asynchronous active-high reset: sysclk  in  1  clock, all state on rising edge.
REQ-007 cpu_reset  in  1  asynchronous active-high reset.
REQ-008 dec_valid  in  1  decode stage holds a valid instruction.
REQ-009 dec_src_addr  in  NSRC*RA_W  source register addresses, operand i at bits [i*RA_W +: RA_W].
REQ-010 dec_src_used  in  NSRC  operand i is actually read.
REQ-011 dec_wreg  in  RA_W  destination register; 0 means no write.
REQ-012 dec_is_load  in  1  instruction is a load.
REQ-013 redirect  in  1  control transfer taken this cycle.
REQ-014 issue  out  1  decode instruction accepted this cycle.
REQ-015 stall  out  1  hold PC and fetch/decode register.
REQ-016 flush  out  1  kill fetch/decode contents.
REQ-017 fwd_sel  out  NSRC*SEL_W  per operand: 0 = register file, k = stage-k result bus; SEL_W = clog2(DEPTH+1).
REQ-018 stall_cnt, flush_cnt  out  32 each  saturating cycle counters.

Function
REQ-019 SHALL keep scoreboard sb[1..DEPTH], each entry {v, wreg, ld}; on every edge sb[k] <= sb[k-1] for k>1.
REQ-020 sb[1] SHALL load {1, dec_wreg, dec_is_load} when issue=1, else a bubble {0,0,0}.
REQ-021 An entry SHALL match operand i when v=1, wreg!=0, wreg==src addr, and dec_src_used[i]=1.
REQ-022 fwd_sel[i] SHALL be the smallest matching k (youngest producer), or 0 when there is no match; output is combinational from sb and inputs.
REQ-023 A hazard SHALL exist when the youngest match for any operand has ld=1 and k < LOAD_READY.
REQ-024 Source address 0 SHALL never match and never cause a hazard.
REQ-025 flush SHALL be 1 in the cycle redirect=1 and in the following FLUSH_CYCLES-1 cycles, using a down-counter.
REQ-026 A redirect while the counter is nonzero SHALL reload the counter.
REQ-027 stall = dec_valid & hazard & ~flush.
REQ-028 issue = dec_valid & ~hazard & ~flush.
REQ-029 Flush SHALL have priority: a simultaneous hazard and redirect yields flush=1, stall=0, issue=0.
REQ-030 stall_cnt SHALL increment on each cycle with stall=1, and flush_cnt on each cycle with flush=1; both hold at 32'hFFFFFFFF.
REQ-031 A stalled instruction SHALL reissue with no extra latency in the first cycle the hazard clears.

Reset
REQ-032 cpu_reset=1 SHALL asynchronously clear all sb entries, the flush counter, stall_cnt and flush_cnt.
REQ-033 While cpu_reset=1, issue, stall, flush and fwd_sel SHALL all be 0, including when reset is asserted mid-stall or mid-flush.

Structure
REQ-034 Package hazard_pkg SHALL hold the sb entry typedef, SEL_W computation, and counter saturation constant.
REQ-035 The per-operand priority match SHALL be a sub-module fwd_match, instantiated NSRC times.

Verification (DEPTH=3, LOAD_READY=2, NSRC=2, FLUSH_CYCLES=1)
REQ-036 Issue an ALU op writing r9, then an op reading r9 as src0 -> second op issues with fwd_sel[0]=1 and stall=0.
REQ-037 Issue a load to r5, then an op reading r5 as src1 -> stall=1 for one cycle, stall_cnt=1, then issue with fwd_sel[1]=2.
REQ-038 Producer with wreg=0, consumer src=0 -> fwd_sel=0, no stall.
REQ-039 r3 written by the ops in sb[1] and sb[3], consumer reads r3 -> fwd_sel=1.
REQ-040 Load-use hazard coincident with redirect -> flush=1, stall=0, issue=0, sb[1] becomes a bubble, flush_cnt increments by 1.
REQ-041 Assert cpu_reset during a stall -> all outputs 0 immediately; after release, a read of a previously pending register gives fwd_sel=0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the hazard controller.
package hazard_pkg;

    // Widest register address a scoreboard entry can hold; RA_W must not exceed it.
    localparam int ADDR_MAX = 16;

    // Value at which the event counters stop counting.
    localparam logic [31:0] CNT_SAT = 32'hFFFF_FFFF;

    typedef struct packed {
        logic                v;
        logic [ADDR_MAX-1:0] wreg;
        logic                ld;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '0;

    // Forwarding select width: encodes 0 (register file) plus stages 1..depth.
    function automatic int sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side request and hazard response signals of the hazard controller.
interface hazard_ctrl_if
    import hazard_pkg::*;
#(
    parameter int RA_W  = 5,
    parameter int NSRC  = 2,
    parameter int DEPTH = 3
);
    localparam int SEL_W = sel_w(DEPTH);

    logic                    dec_valid;
    logic [NSRC*RA_W-1:0]    dec_src_addr;
    logic [NSRC-1:0]         dec_src_used;
    logic [RA_W-1:0]         dec_wreg;
    logic                    dec_is_load;
    logic                    redirect;

    logic                    issue;
    logic                    stall;
    logic                    flush;
    logic [NSRC*SEL_W-1:0]   fwd_sel;
    logic [31:0]             stall_cnt;
    logic [31:0]             flush_cnt;

    modport master (
        output dec_valid, dec_src_addr, dec_src_used, dec_wreg, dec_is_load, redirect,
        input  issue, stall, flush, fwd_sel, stall_cnt, flush_cnt
    );

    modport slave (
        input  dec_valid, dec_src_addr, dec_src_used, dec_wreg, dec_is_load, redirect,
        output issue, stall, flush, fwd_sel, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_ctrl_fwd_match.sv
// Priority match of one source operand against the scoreboard: picks the
// youngest producer and flags a load whose data is not yet on a result bus.
module fwd_match
    import hazard_pkg::*;
#(
    parameter int RA_W       = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2,
    parameter int SEL_W      = 2
) (
    input  sb_entry_t        sb [1:DEPTH],
    input  logic [RA_W-1:0]  src_addr,
    input  logic             src_used,
    output logic [SEL_W-1:0] sel,
    output logic             hazard
);

    // Scan oldest to youngest so the youngest match overrides older ones.
    always_comb begin
        sel    = '0;
        hazard = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (src_used && sb[k].v && (sb[k].wreg != '0) &&
                (sb[k].wreg == ADDR_MAX'(src_addr))) begin
                sel    = SEL_W'(k);
                hazard = sb[k].ld && (k < LOAD_READY);
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: scoreboard of in-flight writers, operand
// forwarding selects, load-use stall, redirect flush and event counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int RA_W         = 5,
    parameter int DEPTH        = 3,
    parameter int NSRC         = 2,
    parameter int LOAD_READY   = 2,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic         sysclk,
    input  logic         cpu_reset,
    hazard_ctrl_if.slave bus
);

    localparam int SEL_W = sel_w(DEPTH);
    localparam int FC_W  = 2;

    sb_entry_t             sb [1:DEPTH];
    logic [FC_W-1:0]       flush_left;
    logic [NSRC-1:0]       op_hazard;
    logic [NSRC*SEL_W-1:0] sel_raw;
    logic                  hazard;
    logic                  flush_int;
    logic                  stall_int;
    logic                  issue_int;
    logic [31:0]           stall_cnt_q;
    logic [31:0]           flush_cnt_q;

    genvar i;
    generate
        for (i = 0; i < NSRC; i++) begin : g_op
            fwd_match #(
                .RA_W       (RA_W),
                .DEPTH      (DEPTH),
                .LOAD_READY (LOAD_READY),
                .SEL_W      (SEL_W)
            ) u_match (
                .sb       (sb),
                .src_addr (bus.dec_src_addr[i*RA_W +: RA_W]),
                .src_used (bus.dec_src_used[i]),
                .sel      (sel_raw[i*SEL_W +: SEL_W]),
                .hazard   (op_hazard[i])
            );
        end
    endgenerate

    // All outputs are forced quiet while reset is held, even mid-stall or mid-flush.
    assign hazard    = |op_hazard;
    assign flush_int = ~cpu_reset & (bus.redirect | (flush_left != '0));
    assign stall_int = ~cpu_reset & bus.dec_valid & hazard & ~flush_int;
    assign issue_int = ~cpu_reset & bus.dec_valid & ~hazard & ~flush_int;

    assign bus.flush     = flush_int;
    assign bus.stall     = stall_int;
    assign bus.issue     = issue_int;
    assign bus.fwd_sel   = cpu_reset ? '0 : sel_raw;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;

    // Scoreboard shift: issued instruction enters stage 1, otherwise a bubble.
    always_ff @(posedge sysclk or posedge cpu_reset) begin
        if (cpu_reset) begin
            for (int k = 1; k <= DEPTH; k++) sb[k] <= SB_BUBBLE;
        end else begin
            if (issue_int) begin
                sb[1] <= '{v: 1'b1, wreg: ADDR_MAX'(bus.dec_wreg), ld: bus.dec_is_load};
            end else begin
                sb[1] <= SB_BUBBLE;
            end
            for (int k = 2; k <= DEPTH; k++) sb[k] <= sb[k-1];
        end
    end

    // Remaining flush cycles after a redirect; a new redirect restarts the count.
    always_ff @(posedge sysclk or posedge cpu_reset) begin
        if (cpu_reset) begin
            flush_left <= '0;
        end else if (bus.redirect) begin
            flush_left <= FC_W'(FLUSH_CYCLES - 1);
        end else if (flush_left != '0) begin
            flush_left <= flush_left - 1'b1;
        end
    end

    // Saturating stall and flush event counters.
    always_ff @(posedge sysclk or posedge cpu_reset) begin
        if (cpu_reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_int && (stall_cnt_q != CNT_SAT)) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush_int && (flush_cnt_q != CNT_SAT)) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a history-based reference model pushes
// expected outputs per cycle, a monitor pops and compares at the falling edge.
module tb_hazard_ctrl;

    localparam int RA_W         = 5;
    localparam int DEPTH        = 3;
    localparam int NSRC         = 2;
    localparam int LOAD_READY   = 2;
    localparam int FLUSH_CYCLES = 1;
    localparam int SEL_W        = 2;

    logic sysclk    = 1'b0;
    logic cpu_reset = 1'b1;

    always #5 sysclk = ~sysclk;

    hazard_ctrl_if #(.RA_W(RA_W), .NSRC(NSRC), .DEPTH(DEPTH)) bus ();

    hazard_ctrl #(
        .RA_W         (RA_W),
        .DEPTH        (DEPTH),
        .NSRC         (NSRC),
        .LOAD_READY   (LOAD_READY),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .sysclk    (sysclk),
        .cpu_reset (cpu_reset),
        .bus       (bus)
    );

    typedef struct {
        bit v;
        int wreg;
        bit ld;
    } rec_t;

    typedef struct {
        bit          issue;
        bit          stall;
        bit          flush;
        logic [3:0]  sel;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    rec_t hist[$];      // hist[0] = instruction issued one cycle ago
    exp_t expq[$];
    int   m_sc;
    int   m_fc;
    int   cyc;
    int   last_redir;
    bit   m_last_stall;
    int   tests;
    int   fails;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic void model_reset();
        rec_t b;
        b.v = 0; b.wreg = 0; b.ld = 0;
        hist.delete();
        for (int k = 0; k < DEPTH; k++) hist.push_back(b);
        m_sc = 0;
        m_fc = 0;
        last_redir = -1000;
        m_last_stall = 0;
    endfunction

    function automatic void model_step(input bit v, input int s0, input int s1,
                                       input bit [1:0] used, input int w, input bit ld,
                                       input bit rd, input bit rst);
        exp_t e;
        rec_t nr;
        int   src[2];
        bit   hz;
        e.issue = 0; e.stall = 0; e.flush = 0; e.sel = '0; e.sc = '0; e.fc = '0;
        cyc++;
        if (rst) begin
            model_reset();
            expq.push_back(e);
            return;
        end
        src[0] = s0;
        src[1] = s1;
        hz = 0;
        for (int i = 0; i < NSRC; i++) begin
            int sel;
            sel = 0;
            for (int k = 1; k <= DEPTH; k++) begin
                if (used[i] && hist[k-1].v && hist[k-1].wreg != 0 && hist[k-1].wreg == src[i]) begin
                    sel = k;
                    if (hist[k-1].ld && k < LOAD_READY) hz = 1;
                    break;
                end
            end
            e.sel[i*SEL_W +: SEL_W] = 2'(sel);
        end
        if (rd) last_redir = cyc;
        e.flush = (cyc - last_redir) < FLUSH_CYCLES;
        e.stall = v && hz && !e.flush;
        e.issue = v && !hz && !e.flush;
        e.sc = 32'(m_sc);
        e.fc = 32'(m_fc);
        m_sc += int'(e.stall);
        m_fc += int'(e.flush);
        m_last_stall = e.stall;
        expq.push_back(e);
        nr.v = e.issue;
        nr.wreg = e.issue ? w : 0;
        nr.ld = e.issue ? ld : 1'b0;
        hist.push_front(nr);
        void'(hist.pop_back());
    endfunction

    // rmode: 0 normal, 1 reset held for the cycle, 2 reset asserted mid-cycle during a stall
    task automatic drive(input bit v, input int s0, input int s1, input bit [1:0] used,
                         input int w, input bit ld, input bit rd, input int rmode);
        @(posedge sysclk);
        #1;
        bus.dec_valid    = v;
        bus.dec_src_addr = {5'(s1), 5'(s0)};
        bus.dec_src_used = used;
        bus.dec_wreg     = 5'(w);
        bus.dec_is_load  = ld;
        bus.redirect     = rd;
        cpu_reset        = (rmode == 1);
        model_step(v, s0, s1, used, w, ld, rd, rmode != 0);
        if (rmode == 2) begin
            #1;
            chk("pre_reset_stall", 32'(bus.stall), 32'd1);
            cpu_reset = 1'b1;
            #1;
            chk("rst_issue", 32'(bus.issue), 32'd0);
            chk("rst_stall", 32'(bus.stall), 32'd0);
            chk("rst_flush", 32'(bus.flush), 32'd0);
            chk("rst_fwd_sel", 32'(bus.fwd_sel), 32'd0);
            chk("rst_stall_cnt", bus.stall_cnt, 32'd0);
        end else begin
            #1;
        end
    endtask

    // Monitor: one expected record per cycle, compared away from the rising edge.
    initial begin
        forever begin
            @(negedge sysclk);
            if (expq.size() > 0) begin
                exp_t e;
                e = expq.pop_front();
                chk("issue", 32'(bus.issue), 32'(e.issue));
                chk("stall", 32'(bus.stall), 32'(e.stall));
                chk("flush", 32'(bus.flush), 32'(e.flush));
                chk("fwd_sel", 32'(bus.fwd_sel), 32'(e.sel));
                chk("stall_cnt", bus.stall_cnt, e.sc);
                chk("flush_cnt", bus.flush_cnt, e.fc);
            end
        end
    end

    initial begin
        logic [3:0] fs;
        bit         pv, pld, prd;
        int         ps0, ps1, pw;
        bit [1:0]   pused;
        tests = 0;
        fails = 0;
        cyc = 0;
        bus.dec_valid    = 1'b0;
        bus.dec_src_addr = '0;
        bus.dec_src_used = '0;
        bus.dec_wreg     = '0;
        bus.dec_is_load  = 1'b0;
        bus.redirect     = 1'b0;
        model_reset();

        drive(0, 0, 0, 2'b00, 0, 0, 0, 1);
        drive(0, 0, 0, 2'b00, 0, 0, 0, 1);
        chk("reset_issue", 32'(bus.issue), 32'd0);
        chk("reset_fwd_sel", 32'(bus.fwd_sel), 32'd0);

        // ALU producer r9 then consumer forwards from stage 1
        drive(1, 0, 0, 2'b00, 9, 0, 0, 0);
        drive(1, 9, 0, 2'b01, 0, 0, 0, 0);
        fs = bus.fwd_sel;
        chk("alu_fwd_sel0", 32'(fs[1:0]), 32'd1);
        chk("alu_issue", 32'(bus.issue), 32'd1);
        chk("alu_stall", 32'(bus.stall), 32'd0);

        // producer with wreg=0 and consumer of r0
        drive(1, 0, 0, 2'b00, 0, 0, 0, 0);
        drive(1, 0, 0, 2'b01, 1, 0, 0, 0);
        chk("r0_fwd_sel", 32'(bus.fwd_sel), 32'd0);
        chk("r0_stall", 32'(bus.stall), 32'd0);

        // load-use: one stall, then reissue forwarding from stage 2
        drive(1, 0, 0, 2'b00, 5, 1, 0, 0);
        drive(1, 0, 5, 2'b10, 2, 0, 0, 0);
        chk("ldu_stall", 32'(bus.stall), 32'd1);
        chk("ldu_issue_held", 32'(bus.issue), 32'd0);
        drive(1, 0, 5, 2'b10, 2, 0, 0, 0);
        fs = bus.fwd_sel;
        chk("ldu_reissue", 32'(bus.issue), 32'd1);
        chk("ldu_fwd_sel1", 32'(fs[3:2]), 32'd2);
        chk("ldu_stall_cnt", bus.stall_cnt, 32'd1);

        // youngest producer wins: r3 in stages 1 and 3
        drive(1, 0, 0, 2'b00, 3, 0, 0, 0);
        drive(1, 0, 0, 2'b00, 7, 0, 0, 0);
        drive(1, 0, 0, 2'b00, 3, 0, 0, 0);
        drive(1, 3, 0, 2'b01, 0, 0, 0, 0);
        fs = bus.fwd_sel;
        chk("youngest_sel", 32'(fs[1:0]), 32'd1);

        // hazard and redirect together: flush wins, no issue
        drive(1, 0, 0, 2'b00, 4, 1, 0, 0);
        drive(1, 4, 0, 2'b01, 6, 0, 1, 0);
        chk("redir_flush", 32'(bus.flush), 32'd1);
        chk("redir_stall", 32'(bus.stall), 32'd0);
        chk("redir_issue", 32'(bus.issue), 32'd0);
        drive(1, 6, 0, 2'b01, 0, 0, 0, 0);
        chk("redir_bubble_sel", 32'(bus.fwd_sel), 32'd0);
        chk("redir_flush_cnt", bus.flush_cnt, 32'd1);
        chk("redir_flush_done", 32'(bus.flush), 32'd0);

        // reset during a stall, then the pending register is forgotten
        drive(1, 0, 0, 2'b00, 8, 1, 0, 0);
        drive(1, 0, 8, 2'b10, 0, 0, 0, 2);
        drive(0, 0, 0, 2'b00, 0, 0, 0, 1);
        drive(1, 0, 8, 2'b10, 0, 0, 0, 0);
        chk("post_rst_sel", 32'(bus.fwd_sel), 32'd0);
        chk("post_rst_issue", 32'(bus.issue), 32'd1);

        // randomized traffic; a stalled instruction is re-presented unchanged
        pv = 0; ps0 = 0; ps1 = 0; pused = 0; pw = 0; pld = 0;
        for (int n = 0; n < 3000; n++) begin
            int rm;
            rm = ($urandom_range(0, 399) == 0) ? 1 : 0;
            prd = ($urandom_range(0, 9) == 0);
            if (!m_last_stall) begin
                pv    = ($urandom_range(0, 3) != 0);
                ps0   = $urandom_range(0, 7);
                ps1   = $urandom_range(0, 7);
                pused = 2'($urandom_range(0, 3));
                pw    = $urandom_range(0, 7);
                pld   = ($urandom_range(0, 2) == 0);
            end
            drive(pv, ps0, ps1, pused, pw, pld, prd, rm);
        end

        drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
        @(negedge sysclk);
        @(negedge sysclk);
        chk("queue_drained", 32'(expq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
